// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader for the instruction memory.
// Optional checksum word: define LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0] DEPTH_W = 32'(2**ADDR_W);
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0] W_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_q;
  logic [31:0] len_q;
  logic [31:0] word_in;
  logic        take;
  logic        last_byte;
  logic        last_word;
  logic        start_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
`endif

  assign take      = in_valid & in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign word_in   = {in_data, asm_q[31:8]};
  assign last_word = (32'(words_loaded) + 32'd1) == len_q;
  assign start_ok  = start & ((state_q == S_IDLE) |
                              (state_q == S_DONE) |
                              (state_q == S_ERR));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take && last_byte) begin
          if (word_in == 32'd0)        state_d = S_FIN;
          else if (word_in > DEPTH_W)  state_d = S_ERR;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        busy    = 1'b1;
        state_d = last_word ? S_FIN : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (take && last_byte)
          state_d = (word_in == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = S_LEN;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_LEN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // word assembly, address and count datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt     <= 2'd0;
      asm_q        <= 32'd0;
      len_q        <= 32'd0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 32'd0;
`endif
    end else if (start_ok) begin
      byte_cnt     <= 2'd0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 32'd0;
`endif
    end else begin
      if (take) begin
        asm_q    <= word_in;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (take && last_byte && state_q == S_LEN) begin
        len_q    <= word_in;
        mem_addr <= '0;
      end
      if (take && last_byte && state_q == S_DATA)
        mem_wdata <= word_in;
      if (state_q == S_WRITE) begin
        words_loaded <= words_loaded + W_ONE;
`ifdef LOADER_CHECKSUM_EN
        csum_q       <= csum_q ^ mem_wdata;
`endif
        if (!last_word) mem_addr <= mem_addr + A_ONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader.
// Expected writes and status come from a list-based load model.
module tb_instr_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;
  logic [ADDR_W:0]   words_loaded;

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  logic [31:0] wq[$];
  bit          prev_acc = 1'b0;
  bit          gap_en = 1'b0;
  bit          abort = 1'b0;

  // write monitor: sampled mid-low-phase, well away from the edge
  always begin
    @(negedge clk);
    #2;
    if (mem_we === 1'b1) begin
      got_q.push_back({mem_addr, mem_wdata});
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_ready: in_ready=%b required 0", in_ready);
      end
      checks++;
      if (prev_acc !== 1'b1) begin
        errors++;
        $display("FAIL write_latency: byte accepted prev cycle=%b required 1",
                 prev_acc);
      end
    end
    prev_acc = (in_valid === 1'b1) && (in_ready === 1'b1) && (reset === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (abort) return;
    if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      abort = 1'b1;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // full load of wq with length n; result checked against the model
  task automatic run_load(input logic [31:0] n, input bit bad_csum,
                          input bit mid_start, input string tag);
    bit          ok_len;
    bit          exp_ok;
    logic [31:0] x;
    logic [3:0]  st;
    logic [3:0]  exp_st;
    logic [ADDR_W:0] exp_wl;
    int          t;
    ok_len = (n <= 32'(DEPTH));
    exp_q.delete();
    x = 32'd0;
    if (ok_len) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({8'(i), wq[i]});
        x = x ^ wq[i];
      end
    end
    exp_ok = ok_len;
`ifdef LOADER_CHECKSUM_EN
    if (bad_csum) exp_ok = 1'b0;
`endif
    exp_wl = ok_len ? (ADDR_W+1)'(n) : '0;
    exp_st = exp_ok ? 4'b0100 : 4'b0011;
    got_q.delete();
    abort = 1'b0;
    pulse_start();
    st = {busy, done, err, cpu_hold};
    checks++;
    if (st !== 4'b1001 || words_loaded !== '0) begin
      errors++;
      $display("FAIL %s_started: busy/done/err/hold=%b wl=%0d required 1001 wl=0",
               tag, st, words_loaded);
    end
    send_word(n);
    if (ok_len) begin
      for (int i = 0; i < int'(n); i++) begin
        send_word(wq[i]);
        if (mid_start && i == 0) pulse_start();
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(bad_csum ? (x ^ 32'h7) : x);
`endif
    end
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #3;
    st = {busy, done, err, cpu_hold};
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL %s_status: busy/done/err/hold=%b required %b",
               tag, st, exp_st);
    end
    checks++;
    if (words_loaded !== exp_wl) begin
      errors++;
      $display("FAIL %s_words_loaded: got %0d required %0d",
               tag, words_loaded, exp_wl);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d",
               tag, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_write%0d: addr/data=%h required %h",
                   tag, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [ADDR_W+46:0] got;
    logic [ADDR_W+46:0] exp;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #2 reset = 1'b0;
    #1;
    got = {in_ready, mem_we, mem_addr, mem_wdata,
           busy, done, err, cpu_hold, words_loaded};
    exp = {1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", got, exp);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wq = '{32'h0000_0013, 32'hDEAD_BEEF};
    run_load(32'd2, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_gaps();
    gap_en = 1'b1;
    wq = '{32'h0000_0013, 32'hDEAD_BEEF};
    run_load(32'd2, 1'b0, 1'b0, "gaps");
    gap_en = 1'b0;
  endtask

  task automatic test_zero_len();
    wq.delete();
    run_load(32'd0, 1'b0, 1'b0, "zero_len");
  endtask

  task automatic test_overflow();
    wq.delete();
    run_load(32'd257, 1'b0, 1'b0, "len257");
    run_load(32'h8000_0001, 1'b0, 1'b0, "len_huge");
  endtask

  task automatic test_full();
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(32'(i));
    run_load(32'd256, 1'b0, 1'b0, "full");
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1][39:32] !== 8'd255) begin
      errors++;
      $display("FAIL full_last_addr: got %h required ff",
               got_q.size() == 0 ? 8'hxx : got_q[got_q.size()-1][39:32]);
    end
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W+14:0] got;
    logic [ADDR_W+14:0] exp;
    int t;
    wq = '{$urandom, $urandom, $urandom};
    got_q.delete();
    abort = 1'b0;
    pulse_start();
    send_word(32'd3);
    send_word(wq[0]);
    send_word(wq[1]);
    t = 0;
    while (got_q.size() < 2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL mid_writes: got %0d required 2", got_q.size());
    end
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    got = {in_ready, mem_we, mem_addr, busy, done, err, cpu_hold, words_loaded};
    exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_reset_values: got %h required %h", got, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    wq = '{$urandom, $urandom, $urandom};
    run_load(32'd3, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] n;
    bit bad;
    for (int k = 0; k < 8; k++) begin
      wq.delete();
      if ($urandom_range(0, 5) == 0) n = 32'(257 + $urandom_range(0, 5000));
      else n = 32'($urandom_range(1, 12));
      if (n <= 32'(DEPTH))
        for (int i = 0; i < int'(n); i++) wq.push_back($urandom);
      gap_en = ($urandom_range(0, 1) == 1);
      bad = ($urandom_range(0, 3) == 0);
      run_load(n, bad, ($urandom_range(0, 1) == 1), "b2b");
    end
    gap_en = 1'b0;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wq = '{32'h1, 32'h2};
    run_load(32'd2, 1'b0, 1'b1, "csum_good");
    run_load(32'd2, 1'b1, 1'b1, "csum_bad");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_overflow();
    test_full();
    test_reset_mid();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
